sync_demux: RTL and testbench
=============================

// Module: sync_demux
// PURPOSE
// - Clocked 1-to-N demultiplexer; the inverse of async_mux. One WIDTH-bit input stream is steered by
//   select to one of CHANNELS output lanes, each with a 1-entry holding register and valid/ready handshake.
// - Sits where a shared byte source fans out to per-lane consumers.
// - Out-of-range select values are discarded and flagged.
// PARAMETERS
// - WIDTH     8  data width per lane
// - CHANNELS  4  number of output lanes (2..16)
// - SEL_BITS  2  select width; must satisfy 2**SEL_BITS >= CHANNELS
// PORTS
// - clk        in   1                 system clock, all logic on rising edge
// - rst        in   1                 synchronous reset, active high
// - in_data    in   WIDTH             input word
// - select     in   SEL_BITS          destination lane for in_data
// - in_valid   in   1                 in_data/select valid this cycle
// - in_ready   out  1                 block accepts word this cycle
// - outputs    out  CHANNELS*WIDTH    lane i data at [i*WIDTH +: WIDTH]
// - out_valid  out  CHANNELS          lane i holding register full
// - out_ready  in   CHANNELS          lane i consumer takes word this cycle
// - sel_err    out  1                 1-cycle pulse: word with select >= CHANNELS was discarded
// BEHAVIOUR
// - Reset (rst=1 at clk edge): all out_valid=0, outputs=0, sel_err=0; held while rst=1.
//   Reset mid-transfer drops any held words; no partial state survives.
// - Per lane: two-state FSM, EMPTY (out_valid=0) / FULL (out_valid=1).
//   - EMPTY -> FULL: accept to this lane.
//   - FULL -> EMPTY: out_ready=1 with no accept to this lane.
//   - FULL -> FULL: out_ready=1 with simultaneous accept. Register reloads with the new word.
//   - FULL holding without out_ready: data and out_valid stable.
// - Accept condition: in_valid & in_ready.
// - in_ready is combinational from registered state and out_ready:
//   - select < CHANNELS: in_ready = !out_valid[select] | out_ready[select].
//   - select >= CHANNELS: in_ready = 1 (word always consumed, then discarded).
// - in_ready must not depend on in_valid.
// - Latency: word accepted at edge N appears on its lane with out_valid=1 from edge N (visible cycle N+1).
// - Only the selected lane is affected by an accept. Other lanes keep their state and handshake independently.
// - Discard (select >= CHANNELS with in_valid=1): no lane changes; sel_err=1 for exactly the next cycle.
//   sel_err is registered and is 0 otherwise.
// - Back-to-back: one word per cycle sustained to one lane when its out_ready=1 continuously.
//   Alternating lanes also sustain one word per cycle.
// - outputs data of an EMPTY lane keeps its last value (don't-care to consumers). After reset it is 0.
// - No combinational path from in_data to outputs.
// TESTING
// - Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0000, outputs=0, sel_err=0 throughout.
// - Routing: all out_ready=1; send 0x0F,0xF0,0xCC,0xAA with select 0..3 on consecutive cycles.
//   -> each lane i shows its byte 1 cycle after accept, out_valid one-hot; in_ready=1 every cycle.
// - Backpressure: out_ready[2]=0; send 0x11 then 0x22 to lane 2.
//   -> 0x11 held, in_ready=0 on the second word until out_ready[2]=1.
//   -> then 0x22 loads in that same cycle (FULL->FULL), no loss or duplication.
// - Lane independence: lane 1 FULL and stalled; send 0x5A to lane 3.
//   -> accepted immediately; lane 1 unchanged.
// - Bad select: CHANNELS=3, select=3, in_data=0x77.
//   -> in_ready=1, sel_err pulse 1 cycle, no out_valid change.
// - Reset mid-operation: lanes 0,2 FULL and stalled; pulse rst 1 cycle.
//   -> out_valid=0000 next cycle; a following word to lane 0 delivers normally.

Source files
------------

// File: rtl/sync_demux.sv
// Clocked 1-to-N demultiplexer: one input stream is steered by select into per-lane
// single-entry holding registers, each drained through its own valid/ready handshake.
module sync_demux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_BITS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_BITS-1:0]       select,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] outputs,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic                      sel_err
);

    localparam int NSEL = 1 << SEL_BITS;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

    logic                sel_ok;
    logic [NSEL-1:0]     lane_free;
    logic [CHANNELS-1:0] accept;
    logic                sel_err_reg;

    assign sel_ok = ({1'b0, select} < (SEL_BITS + 1)'(CHANNELS));

    // Unused select codes map to "not free"; in_ready ignores them via sel_ok anyway.
    generate
        for (genvar gi = 0; gi < NSEL; gi++) begin : g_free
            if (gi < CHANNELS) begin : g_real
                assign lane_free[gi] = !out_valid[gi] | out_ready[gi];
            end else begin : g_pad
                assign lane_free[gi] = 1'b0;
            end
        end
    endgenerate

    // Out-of-range words are always consumed so a bad select can never stall the source.
    assign in_ready = sel_ok ? lane_free[select] : 1'b1;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
            lane_state_t      state_reg;
            logic [WIDTH-1:0] data_reg;

            assign accept[gi] = in_valid & in_ready & (select == SEL_BITS'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= EMPTY;
                    data_reg  <= '0;
                end else begin
                    case (state_reg)
                        EMPTY: begin
                            if (accept[gi]) begin
                                state_reg <= FULL;
                                data_reg  <= in_data;
                            end
                        end
                        FULL: begin
                            if (accept[gi]) begin
                                data_reg <= in_data;
                            end else if (out_ready[gi]) begin
                                state_reg <= EMPTY;
                            end
                        end
                        default: state_reg <= EMPTY;
                    endcase
                end
            end

            assign out_valid[gi]                = (state_reg == FULL);
            assign outputs[gi*WIDTH +: WIDTH]   = data_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_reg <= 1'b0;
        end else begin
            sel_err_reg <= in_valid & !sel_ok;
        end
    end

    assign sel_err = sel_err_reg;

endmodule

// File: tb/tb_sync_demux.sv
// Scoreboarded bench for sync_demux: stimulus pushes expected words per lane, a monitor
// pops and compares on every lane handshake. A 3-lane instance covers the bad-select case.
module tb_sync_demux;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic [1:0]  select;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dout;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic        sel_err;

    logic [7:0]  in_data3;
    logic [1:0]  select3;
    logic        in_valid3;
    logic        in_ready3;
    logic [23:0] dout3;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3;
    logic        sel_err3;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q [4][$];

    sync_demux #(.WIDTH(8), .CHANNELS(4), .SEL_BITS(2)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .select(select), .in_valid(in_valid),
        .in_ready(in_ready), .outputs(dout), .out_valid(out_valid), .out_ready(out_ready),
        .sel_err(sel_err)
    );

    sync_demux #(.WIDTH(8), .CHANNELS(3), .SEL_BITS(2)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .select(select3), .in_valid(in_valid3),
        .in_ready(in_ready3), .outputs(dout3), .out_valid(out_valid3), .out_ready(out_ready3),
        .sel_err(sel_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    // Monitor: at the falling edge, a lane with valid&ready will transfer on the next rising edge.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (out_valid[i] === 1'b1 && out_ready[i] === 1'b1 && rst === 1'b0) begin
                if (exp_q[i].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL lane%0d_unexpected: got %0h expected none", i, dout[i*8 +: 8]);
                end else begin
                    check($sformatf("lane%0d_data", i), 32'(dout[i*8 +: 8]), 32'(exp_q[i].pop_front()));
                end
            end
        end
    end

    task automatic send(input logic [1:0] s, input logic [7:0] d, input int max_wait);
        int n;
        @(posedge clk); #1;
        select   = s;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (in_ready !== 1'b1 && n < max_wait) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("in_ready_lane%0d", s), 32'(in_ready), 32'd1);
        if (in_ready === 1'b1) exp_q[s].push_back(d);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rt [4];
        rt = '{8'h0F, 8'hF0, 8'hCC, 8'hAA};

        // Reset held two cycles with traffic present on both instances
        rst = 1'b1; in_valid = 1'b1; select = 2'd0; in_data = 8'hAB; out_ready = 4'h0;
        in_valid3 = 1'b1; select3 = 2'd3; in_data3 = 8'h77; out_ready3 = 3'b000;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_out_valid", 32'(out_valid), 32'h0);
            check("rst_outputs", dout, 32'h0);
            check("rst_sel_err", 32'(sel_err), 32'h0);
            check("rst_sel_err3", 32'(sel_err3), 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; in_valid3 = 1'b0;

        // Routing to every lane on consecutive cycles
        out_ready = 4'hF;
        send(2'd0, rt[0], 0);
        for (int i = 1; i < 4; i++) begin
            send(2'(i), rt[i], 0);
            check("route_onehot", 32'(out_valid), 32'(1 << (i - 1)));
        end
        idle();
        @(negedge clk);
        check("route_last", 32'(out_valid), 32'h8);
        @(negedge clk);
        check("route_drained", 32'(out_valid), 32'h0);

        // Backpressure on lane 2, then FULL->FULL reload
        out_ready = 4'b1011;
        send(2'd2, 8'h11, 0);
        @(posedge clk); #1;
        select = 2'd2; in_data = 8'h22; in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready), 32'h0);
            check("bp_hold_data", 32'(dout[23:16]), 32'h11);
            @(posedge clk); #1;
        end
        out_ready = 4'hF;
        @(negedge clk);
        check("bp_in_ready_release", 32'(in_ready), 32'h1);
        if (in_ready === 1'b1) exp_q[2].push_back(8'h22);
        idle();
        @(negedge clk);
        check("bp_reload_valid", 32'(out_valid), 32'h4);
        @(negedge clk);
        check("bp_drained", 32'(out_valid), 32'h0);

        // Lane independence: lane 1 stalled, lane 3 still accepts
        out_ready = 4'b1101;
        send(2'd1, 8'h3C, 0);
        send(2'd3, 8'h5A, 0);
        check("ind_lane1_only", 32'(out_valid), 32'h2);
        idle();
        @(negedge clk);
        check("ind_both_full", 32'(out_valid), 32'hA);
        check("ind_lane1_data", 32'(dout[15:8]), 32'h3C);
        @(posedge clk); #1;
        out_ready = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check("ind_drained", 32'(out_valid), 32'h0);
        check("main_sel_err", 32'(sel_err), 32'h0);

        // Bad select on the 3-lane instance, with lane 2 already holding a word
        @(posedge clk); #1;
        select3 = 2'd2; in_data3 = 8'h44; in_valid3 = 1'b1;
        @(posedge clk); #1;
        select3 = 2'd3; in_data3 = 8'h77;
        @(negedge clk);
        check("bad_in_ready", 32'(in_ready3), 32'h1);
        check("bad_prior_valid", 32'(out_valid3), 32'h4);
        check("bad_sel_err_before", 32'(sel_err3), 32'h0);
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        @(negedge clk);
        check("bad_sel_err_pulse", 32'(sel_err3), 32'h1);
        check("bad_valid_kept", 32'(out_valid3), 32'h4);
        check("bad_data_kept", 32'(dout3[23:16]), 32'h44);
        @(negedge clk);
        check("bad_sel_err_end", 32'(sel_err3), 32'h0);

        // Reset mid-operation drops stalled words on lanes 0 and 2
        out_ready = 4'b1010;
        send(2'd0, 8'h01, 0);
        send(2'd2, 8'h02, 0);
        idle();
        @(negedge clk);
        check("mid_full", 32'(out_valid), 32'h5);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_outputs", dout, 32'h0);
        check("mid_rst_valid3", 32'(out_valid3), 32'h0);
        out_ready = 4'hF;
        send(2'd0, 8'h99, 2);
        idle();
        @(negedge clk);
        check("mid_after_valid", 32'(out_valid), 32'h1);
        @(negedge clk);
        check("mid_after_drained", 32'(out_valid), 32'h0);

        for (int i = 0; i < 4; i++) begin
            check($sformatf("queue%0d_empty", i), 32'(exp_q[i].size()), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
